// File: rtl/seq_div_8by4.sv
// seq_div_8by4
// Sequential 8-bit by 4-bit unsigned restoring divider. A start pulse in IDLE
// captures both operands. One quotient bit is produced per clock over eight
// RUN cycles. The result is then held on registered outputs, and a one-cycle
// done pulse marks its arrival. A zero divisor is detected in the first RUN
// cycle and short-circuits straight to DONE with an all-ones quotient.

module seq_div_8by4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic [7:0] quot,
   output logic [3:0] rem,
   output logic       busy,
   output logic       done,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT      r_state;
   stateT      w_nextState;

   // Working registers: quotient/dividend shift register, captured divisor,
   // 5-bit partial remainder and the step counter (7 down to 0).
   logic [7:0] r_q;
   logic [3:0] r_d;
   logic [4:0] r_r;
   logic [2:0] r_count;

   // Result registers; these only change on the edge that enters DONE.
   logic [7:0] r_quot;
   logic [3:0] r_rem;
   logic       r_divByZero;

   logic       w_accept;
   logic       w_zeroDivisor;
   logic       w_lastStep;
   logic [5:0] w_rShift;
   logic [5:0] w_trial;
   logic       w_fits;
   logic [4:0] w_rNext;
   logic [7:0] w_qNext;

   // A start is only honoured while IDLE; starts in RUN or DONE are dropped.
   assign w_accept      = (r_state == IDLE) && start;

   // The divisor check uses the captured copy. This keeps the operands frozen
   // once accepted, and it makes the zero case take exactly one cycle.
   assign w_zeroDivisor = (r_d == 4'd0);

   // The step that runs while the counter reads zero produces the final bit.
   assign w_lastStep    = (r_count == 3'd0);

   // One restoring step. The remainder is shifted left with the dividend MSB
   // entering its LSB. The remainder is widened to 6 bits, so the borrow of
   // the trial subtraction shows up as a sign bit. R stays below D <= 15, so
   // the shifted value never exceeds 29. Because of that, bit 5 of the trial
   // result is a true sign.
   assign w_rShift = {r_r, r_q[7]};
   assign w_trial  = w_rShift - {2'b00, r_d};
   assign w_fits   = ~w_trial[5];
   assign w_rNext  = w_fits ? w_trial[4:0] : w_rShift[4:0];
   assign w_qNext  = {r_q[6:0], w_fits};

   // State register with synchronous reset; reset aborts any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last step
   // (or immediately for a zero divisor), DONE -> IDLE unconditionally.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (w_zeroDivisor || w_lastStep) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath: operand capture on accept, one restoring step per RUN cycle,
   // and the result registers loaded on the edge that moves RUN into DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q         <= 8'd0;
         r_d         <= 4'd0;
         r_r         <= 5'd0;
         r_count     <= 3'd0;
         r_quot      <= 8'd0;
         r_rem       <= 4'd0;
         r_divByZero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_q     <= dividend;
                  r_d     <= divisor;
                  r_r     <= 5'd0;
                  r_count <= 3'd7;
               end
            end
            RUN: begin
               if (w_zeroDivisor) begin
                  r_quot      <= 8'hFF;
                  r_rem       <= 4'h0;
                  r_divByZero <= 1'b1;
               end else begin
                  r_q     <= w_qNext;
                  r_r     <= w_rNext;
                  r_count <= r_count - 3'd1;
                  if (w_lastStep) begin
                     r_quot      <= w_qNext;
                     r_rem       <= w_rNext[3:0];
                     r_divByZero <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output decode. Every output comes from a register: busy and done are
   // decoded from the state register, and no input reaches an output
   // combinationally.
   always_comb begin
      busy        = (r_state != IDLE);
      done        = (r_state == DONE);
      quot        = r_quot;
      rem         = r_rem;
      div_by_zero = r_divByZero;
   end

endmodule
